// File: rtl/home_auto_pkg.sv
// Shared definitions for the home-automation front end: motion FSM encoding
// and the default timing constants also used by smart_camera benches.
package home_auto_pkg;

    typedef logic [1:0] ms_state_t;

    localparam ms_state_t MS_IDLE    = 2'd0;
    localparam ms_state_t MS_QUALIFY = 2'd1;
    localparam ms_state_t MS_ACTIVE  = 2'd2;
    localparam ms_state_t MS_LOCKOUT = 2'd3;

    localparam int DEF_SYNC_STAGES     = 2;
    localparam int DEF_DEBOUNCE_CYCLES = 16;
    localparam int DEF_LOCKOUT_CYCLES  = 64;
    localparam int DEF_CNT_W           = 8;

    // True when a cycle count is non-zero and representable in a width-bit counter.
    function automatic logic fits_cnt(input int value, input int width);
        return (value >= 1) && (value <= (1 << width) - 1);
    endfunction

endpackage

// File: rtl/motion_sensor_conditioner_if.sv
// Signal bundle between the raw sensor inputs, the conditioner and its consumers.
interface motion_sensor_conditioner_if
    import home_auto_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W
);
    logic             pir_raw;
    logic             remote_btn_raw;
    logic             enable;
    logic             motion_detected;
    logic             remote_control;
    logic             motion_active;
    logic [CNT_W-1:0] event_count;
    ms_state_t        motion_state;
    logic             remote_level;

    // No valid/ready pair here: motion_detected and remote_control are
    // single-cycle event strobes with no back-pressure; the consumer must
    // sample them every cycle. Levels and the counter are plain status.
    modport slave (
        input  pir_raw, remote_btn_raw, enable,
        output motion_detected, remote_control, motion_active, event_count,
        output motion_state, remote_level
    );

    modport master (
        output pir_raw, remote_btn_raw, enable,
        input  motion_detected, remote_control, motion_active, event_count,
        input  motion_state, remote_level
    );
endinterface

// File: rtl/input_debouncer.sv
// Synchroniser plus consecutive-high debouncer; emits a level and a one-cycle rise strobe.
module input_debouncer #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int CNT_W           = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic level,
    output logic rise
);
    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   level_q, level_d;
    logic                   rise_q, rise_d;
    logic                   in_s;

    assign in_s = sync_q[SYNC_STAGES-1];

    always_comb begin
        sync_d  = {sync_q[SYNC_STAGES-2:0], raw};
        cnt_d   = cnt_q;
        level_d = level_q;
        rise_d  = 1'b0;
        if (!in_s) begin
            cnt_d   = '0;
            level_d = 1'b0;
        end else if (!level_q) begin
            if (cnt_q == DEB_LAST) begin
                level_d = 1'b1;
                rise_d  = 1'b1;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q  <= '0;
            cnt_q   <= '0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            rise_q  <= rise_d;
        end
    end

    assign level = level_q;
    assign rise  = rise_q;
endmodule

// File: rtl/motion_sensor_conditioner.sv
// PIR debounce/qualify/lockout FSM plus debounced remote button, producing clean
// single-cycle event strobes and a saturating motion event counter.
module motion_sensor_conditioner
    import home_auto_pkg::*;
#(
    parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int LOCKOUT_CYCLES  = DEF_LOCKOUT_CYCLES,
    parameter int CNT_W           = DEF_CNT_W
) (
    input  logic                        clk,
    input  logic                        rst,
    motion_sensor_conditioner_if.slave  bus
);
    localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCKOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] EVT_MAX   = '1;

    if (SYNC_STAGES < 2) begin : g_bad_sync
        $error("SYNC_STAGES must be at least 2");
    end
    if (!fits_cnt(DEBOUNCE_CYCLES, CNT_W)) begin : g_bad_deb
        $error("DEBOUNCE_CYCLES must be in 1..2**CNT_W-1");
    end
    if (!fits_cnt(LOCKOUT_CYCLES, CNT_W)) begin : g_bad_lock
        $error("LOCKOUT_CYCLES must be in 1..2**CNT_W-1");
    end

    logic [SYNC_STAGES-1:0] pir_sync_q, pir_sync_d;
    ms_state_t              state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   motion_detected_q, motion_detected_d;
    logic                   motion_active_q, motion_active_d;
    logic [CNT_W-1:0]       event_count_q, event_count_d;
    logic                   pir_s;

    assign pir_s = pir_sync_q[SYNC_STAGES-1];

    always_comb begin
        pir_sync_d        = {pir_sync_q[SYNC_STAGES-2:0], bus.pir_raw};
        state_d           = state_q;
        cnt_d             = cnt_q;
        motion_detected_d = 1'b0;
        case (state_q)
            MS_IDLE: begin
                if (pir_s) begin
                    // A one-cycle debounce qualifies on the very first high sample.
                    if (DEB_LAST == '0) begin
                        state_d           = MS_ACTIVE;
                        cnt_d             = '0;
                        motion_detected_d = 1'b1;
                    end else begin
                        state_d = MS_QUALIFY;
                        cnt_d   = CNT_W'(1);
                    end
                end
            end
            MS_QUALIFY: begin
                if (!pir_s) begin
                    state_d = MS_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == DEB_LAST) begin
                    state_d           = MS_ACTIVE;
                    cnt_d             = '0;
                    motion_detected_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            MS_ACTIVE: begin
                if (!pir_s) begin
                    state_d = MS_LOCKOUT;
                    cnt_d   = '0;
                end
            end
            MS_LOCKOUT: begin
                if (cnt_q == LOCK_LAST) begin
                    state_d = MS_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = MS_IDLE;
                cnt_d   = '0;
            end
        endcase
        if (!bus.enable) begin
            state_d           = MS_IDLE;
            cnt_d             = '0;
            motion_detected_d = 1'b0;
        end
        motion_active_d = (state_d == MS_ACTIVE);
        event_count_d   = (motion_detected_d && (event_count_q != EVT_MAX))
                          ? event_count_q + CNT_W'(1) : event_count_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pir_sync_q        <= '0;
            state_q           <= MS_IDLE;
            cnt_q             <= '0;
            motion_detected_q <= 1'b0;
            motion_active_q   <= 1'b0;
            event_count_q     <= '0;
        end else begin
            pir_sync_q        <= pir_sync_d;
            state_q           <= state_d;
            cnt_q             <= cnt_d;
            motion_detected_q <= motion_detected_d;
            motion_active_q   <= motion_active_d;
            event_count_q     <= event_count_d;
        end
    end

    input_debouncer #(
        .SYNC_STAGES    (SYNC_STAGES),
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .CNT_W          (CNT_W)
    ) u_remote (
        .clk  (clk),
        .rst  (rst),
        .raw  (bus.remote_btn_raw),
        .level(bus.remote_level),
        .rise (bus.remote_control)
    );

    assign bus.motion_detected = motion_detected_q;
    assign bus.motion_active   = motion_active_q;
    assign bus.event_count     = event_count_q;
    assign bus.motion_state    = state_q;
endmodule

// File: tb/tb_motion_sensor_conditioner.sv
// Randomised and directed bench with a run-length reference model and a pulse scoreboard.
module tb_motion_sensor_conditioner;
    localparam int S    = 2;
    localparam int D    = 4;
    localparam int L    = 8;
    localparam int CW   = 4;
    localparam int W    = 32 + 2 + CW;
    localparam int EMAX = (1 << CW) - 1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    motion_sensor_conditioner_if #(.CNT_W(CW)) bus_if ();

    motion_sensor_conditioner #(
        .SYNC_STAGES    (S),
        .DEBOUNCE_CYCLES(D),
        .LOCKOUT_CYCLES (L),
        .CNT_W          (CW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus_if)
    );

    logic [W-1:0] exp_q[$];
    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Reference model state: raw-sample delay lines, length of the current
    // qualifying high run, presence flag, remaining ignored cycles.
    bit p_hist[$];
    bit b_hist[$];
    int m_run, m_lock, r_run, ev_cnt;
    bit m_active;
    bit ps, bs, mp, rp;

    always @(posedge clk or posedge rst) begin
        cyc++;
        if (rst) begin
            p_hist.delete();
            b_hist.delete();
            repeat (S) begin
                p_hist.push_back(1'b0);
                b_hist.push_back(1'b0);
            end
            m_run    = 0;
            m_lock   = 0;
            r_run    = 0;
            ev_cnt   = 0;
            m_active = 1'b0;
            exp_q.delete();
        end else begin
            ps = p_hist.pop_back();
            p_hist.push_front(bus_if.pir_raw);
            bs = b_hist.pop_back();
            b_hist.push_front(bus_if.remote_btn_raw);
            mp = 1'b0;
            rp = 1'b0;
            if (!bus_if.enable) begin
                m_run    = 0;
                m_lock   = 0;
                m_active = 1'b0;
            end else if (m_lock > 0) begin
                m_lock--;
            end else if (m_active) begin
                if (!ps) begin
                    m_active = 1'b0;
                    m_lock   = L;
                end
            end else if (ps) begin
                m_run++;
                if (m_run == D) begin
                    mp       = 1'b1;
                    m_active = 1'b1;
                    m_run    = 0;
                end
            end else begin
                m_run = 0;
            end
            if (mp && ev_cnt < EMAX) ev_cnt++;
            if (bs) begin
                if (r_run <= D) r_run++;
                rp = (r_run == D);
            end else begin
                r_run = 0;
            end
            if (mp || rp) exp_q.push_back({cyc[31:0], mp, rp, ev_cnt[CW-1:0]});
        end
    end

    logic [W-1:0] e;
    always @(negedge clk) begin
        if (rst) begin
            total++;
            if (bus_if.motion_detected || bus_if.remote_control || bus_if.motion_active ||
                bus_if.event_count != '0) begin
                bad++;
                $display("FAIL reset_outputs: md=%0b rc=%0b ma=%0b cnt=%0d, required all 0",
                         bus_if.motion_detected, bus_if.remote_control,
                         bus_if.motion_active, bus_if.event_count);
            end
        end else begin
            total++;
            if (bus_if.motion_active !== m_active) begin
                bad++;
                $display("FAIL motion_active cyc=%0d: got %0b, required %0b",
                         cyc, bus_if.motion_active, m_active);
            end
            total++;
            if (int'(bus_if.event_count) != ev_cnt) begin
                bad++;
                $display("FAIL event_count cyc=%0d: got %0d, required %0d",
                         cyc, bus_if.event_count, ev_cnt);
            end
            while (exp_q.size() > 0 && int'(exp_q[0][W-1:CW+2]) < cyc) begin
                e = exp_q.pop_front();
                total++;
                bad++;
                $display("FAIL missed_pulse: got no pulse, required md=%0b rc=%0b at cyc %0d",
                         e[CW+1], e[CW], e[W-1:CW+2]);
            end
            if (bus_if.motion_detected || bus_if.remote_control) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_pulse cyc=%0d: got md=%0b rc=%0b, required none",
                             cyc, bus_if.motion_detected, bus_if.remote_control);
                end else begin
                    e = exp_q.pop_front();
                    if (int'(e[W-1:CW+2]) != cyc || e[CW+1] !== bus_if.motion_detected ||
                        e[CW] !== bus_if.remote_control || e[CW-1:0] !== bus_if.event_count) begin
                        bad++;
                        $display("FAIL pulse cyc=%0d: got md=%0b rc=%0b cnt=%0d, required cyc=%0d md=%0b rc=%0b cnt=%0d",
                                 cyc, bus_if.motion_detected, bus_if.remote_control,
                                 bus_if.event_count, e[W-1:CW+2], e[CW+1], e[CW], e[CW-1:0]);
                    end
                end
            end
        end
    end

    task automatic drive(input bit p, input bit b, input bit en, input int n);
        bus_if.pir_raw        = p;
        bus_if.remote_btn_raw = b;
        bus_if.enable         = en;
        repeat (n) @(negedge clk);
    endtask

    initial begin
        rst                   = 1'b1;
        bus_if.pir_raw        = 1'b0;
        bus_if.remote_btn_raw = 1'b0;
        bus_if.enable         = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Reset mid-operation with both inputs high, then requalification.
        drive(1, 1, 1, 3);
        #2 rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        drive(1, 1, 1, 12);
        drive(0, 0, 1, 15);

        // Short glitch.
        drive(1, 0, 1, 3);
        drive(0, 0, 1, 10);

        // Qualified motion, drop, re-rise inside lockout.
        drive(1, 0, 1, 20);
        drive(0, 0, 1, 3);
        drive(1, 0, 1, 25);
        drive(0, 0, 1, 20);

        // Remote and motion rising together.
        drive(1, 1, 1, 30);
        drive(0, 0, 1, 20);

        // Enable dropped during qualification.
        drive(1, 0, 1, 4);
        drive(1, 0, 0, 2);
        drive(1, 0, 1, 12);
        drive(0, 0, 1, 15);

        repeat (40) begin
            drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  ($urandom_range(0, 9) != 0), int'($urandom_range(1, 20)));
        end
        drive(0, 0, 1, 20);

        // Drive the event counter into saturation.
        repeat (18) begin
            drive(1, 0, 1, 8);
            drive(0, 0, 1, 12);
        end

        total++;
        if (int'(bus_if.event_count) != EMAX) begin
            bad++;
            $display("FAIL event_count_saturated: got %0d, required %0d", bus_if.event_count, EMAX);
        end
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL pending_expectations: got %0d left, required 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
